// File: rtl/usb_nint_pkg.sv
// usb_nint_gen shared definitions.
// Register map, CONTROL bit indices and pulser FSM states.
package usb_nint_pkg;

  localparam logic [1:0] ADDR_STATUS  = 2'd0;
  localparam logic [1:0] ADDR_ENABLE  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_PENDING = 2'd3;

  localparam int CTRL_MODE  = 0;
  localparam int CTRL_FORCE = 1;

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    GAP
  } pstate_e;

endpackage

// File: rtl/usb_nint_gen_if.sv
// Avalon-MM slave bundle for usb_nint_gen.
// Master drives the access, slave returns registered readdata.
interface usb_nint_gen_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/usb_nint_pulser.sv
// Pulse-mode nINT generator: request latch, IDLE/ASSERT/GAP FSM
// and a load-on-entry down counter.
module usb_nint_pulser
  import usb_nint_pkg::*;
#(
  parameter int PULSE_CYCLES = 16,
  parameter int GAP_CYCLES   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pend_any,
  input  logic evt,
  input  logic restart,
  output logic nint
);

  localparam int MAXC = (PULSE_CYCLES > GAP_CYCLES) ?
                        PULSE_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] P_LOAD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] G_LOAD = CW'(GAP_CYCLES - 1);

  pstate_e       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          prev_q, prev_d;
  logic          nint_q, nint_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nint_d  = nint_q;
    prev_d  = pend_any;
    req_d   = req_q | (pend_any & ~prev_q) | evt;
    if (restart) begin
      state_d = IDLE;
      cnt_d   = '0;
      req_d   = 1'b0;
      nint_d  = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Clear beats a same-edge set: the event strobe and
          // the pend_any rise it causes land one cycle apart.
          if (req_q) begin
            state_d = ASSERT;
            cnt_d   = P_LOAD;
            req_d   = 1'b0;
            nint_d  = 1'b0;
          end
        end
        ASSERT: begin
          if (cnt_q == '0) begin
            state_d = GAP;
            cnt_d   = G_LOAD;
            nint_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        GAP: begin
          if (cnt_q == '0) state_d = IDLE;
          else cnt_d = cnt_q - 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      prev_q  <= 1'b0;
      nint_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      prev_q  <= prev_d;
      nint_q  <= nint_d;
    end
  end

  assign nint = nint_q;

endmodule

// File: rtl/usb_nint_gen.sv
// USB sideband interrupt generator: sticky STATUS, ENABLE mask,
// CONTROL mode/force, registered read mux and active-low nint.
module usb_nint_gen
  import usb_nint_pkg::*;
#(
  parameter int EVENTS       = 8,
  parameter int PULSE_CYCLES = 16,
  parameter int GAP_CYCLES   = 4
) (
  input  logic              clk,
  input  logic              reset,
  usb_nint_gen_if.slave     bus,
  input  logic [EVENTS-1:0] event_in,
  output logic              nint
);

  logic [EVENTS-1:0] status_q, status_d;
  logic [EVENTS-1:0] enable_q, enable_d;
  logic [1:0]        ctrl_q, ctrl_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              lvl_q, lvl_d;
  logic              wr, wr_status, wr_enable, wr_ctrl;
  logic [EVENTS-1:0] clr_mask;
  logic              pend_any;
  logic              pulse_nint;

  assign wr        = bus.chipselect & ~bus.write_n;
  assign wr_status = wr && (bus.address == ADDR_STATUS);
  assign wr_enable = wr && (bus.address == ADDR_ENABLE);
  assign wr_ctrl   = wr && (bus.address == ADDR_CONTROL);
  assign clr_mask  = wr_status ? bus.writedata[EVENTS-1:0] : '0;
  assign pend_any  = (|(status_q & enable_q)) | ctrl_q[CTRL_FORCE];

  always_comb begin
    status_d = (status_q & ~clr_mask) | event_in;
    enable_d = wr_enable ? bus.writedata[EVENTS-1:0] : enable_q;
    ctrl_d   = wr_ctrl ? bus.writedata[1:0] : ctrl_q;
    lvl_d    = wr_ctrl | ~pend_any;
    rdata_d  = '0;
    unique case (bus.address)
      ADDR_STATUS:  rdata_d = 32'(status_q);
      ADDR_ENABLE:  rdata_d = 32'(enable_q);
      ADDR_CONTROL: rdata_d = {30'd0, ctrl_q};
      ADDR_PENDING: rdata_d = 32'(status_q & enable_q);
      default:      rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      status_q <= '0;
      enable_q <= '0;
      ctrl_q   <= '0;
      rdata_q  <= '0;
      lvl_q    <= 1'b1;
    end else begin
      status_q <= status_d;
      enable_q <= enable_d;
      ctrl_q   <= ctrl_d;
      rdata_q  <= rdata_d;
      lvl_q    <= lvl_d;
    end
  end

  usb_nint_pulser #(
    .PULSE_CYCLES (PULSE_CYCLES),
    .GAP_CYCLES   (GAP_CYCLES)
  ) u_pulser (
    .clk      (clk),
    .reset    (reset),
    .pend_any (pend_any),
    .evt      (|(event_in & enable_q)),
    .restart  (wr_ctrl),
    .nint     (pulse_nint)
  );

  assign bus.readdata = rdata_q;
  assign nint = ctrl_q[CTRL_MODE] ? pulse_nint : lvl_q;

endmodule

// File: tb/tb_usb_nint_gen.sv
// Directed bench for usb_nint_gen with a queue-based scoreboard.
// Expected values are pushed when stimulus is driven.
module tb_usb_nint_gen;

  localparam int EV = 8;
  localparam int P  = 16;
  localparam int G  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [EV-1:0] event_in;
  logic          nint;
  int            n_cmp = 0;
  int            n_err = 0;
  logic [31:0]   exp_q[$];
  logic          trace[64];

  usb_nint_gen_if bus();

  usb_nint_gen #(
    .EVENTS       (EV),
    .PULSE_CYCLES (P),
    .GAP_CYCLES   (G)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .event_in (event_in),
    .nint     (nint)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp,
                    input string tag);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    exp_q.push_back(exp);
    tick();
    chk(tag, bus.readdata, exp_q.pop_front());
    bus.chipselect = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic count_low(input int n, output int lows);
    lows = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (nint !== 1'b1) lows++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int lows;
    int starts[$];
    int lens[$];
    int run;
    int gap_min;

    reset          = 1'b1;
    event_in       = '0;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    tick();
    tick();
    chk("rst_nint", nint, 1);
    chk("rst_rdata", bus.readdata, 0);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), 0, "rst_read");
      chk("rst_nint_hi", nint, 1);
    end

    // Level mode assert / W1C deassert.
    wr(2'd1, 32'h01);
    event_in = 8'h01;
    tick();
    event_in = '0;
    chk("lvl_n1", nint, 1);
    tick();
    chk("lvl_n2", nint, 0);
    wr(2'd0, 32'h01);
    chk("lvl_clr1", nint, 0);
    tick();
    chk("lvl_clr2", nint, 1);
    rd(2'd0, 0, "lvl_status");

    // Status sets regardless of enable.
    wr(2'd1, 32'h00);
    event_in = 8'h08;
    tick();
    event_in = '0;
    rd(2'd0, 32'h08, "dis_status");
    rd(2'd3, 32'h00, "dis_pending");
    chk("dis_nint", nint, 1);
    wr(2'd1, 32'h08);
    chk("en_nint1", nint, 1);
    tick();
    chk("en_nint2", nint, 0);
    wr(2'd3, 32'hFF);
    rd(2'd3, 32'h08, "pend_ro");
    wr(2'd0, 32'h08);
    wr(2'd1, 32'h00);

    // Same-cycle set and clear: set wins.
    event_in = 8'h04;
    wr(2'd0, 32'h04);
    event_in = '0;
    rd(2'd0, 32'h04, "set_wins");
    wr(2'd0, 32'h04);
    rd(2'd0, 0, "w1c");

    // FORCE in level mode.
    wr(2'd2, 32'h2);
    chk("force1", nint, 1);
    tick();
    chk("force2", nint, 0);
    rd(2'd2, 32'h2, "ctrl_rb");
    wr(2'd2, 32'h0);
    tick();
    chk("unforce", nint, 1);

    // Pulse mode: three events during one pulse -> two pulses.
    wr(2'd1, 32'h01);
    wr(2'd2, 32'h01);
    exp_q.push_back(1);
    exp_q.push_back(P);
    exp_q.push_back(1 + P + G + 1);
    exp_q.push_back(P);
    for (int i = 0; i < 60; i++) begin
      event_in = (i == 0 || i == 3 || i == 8) ? 8'h01 : 8'h00;
      tick();
      trace[i] = nint;
    end
    event_in = '0;
    run = 0;
    gap_min = 1000;
    for (int i = 0; i < 60; i++) begin
      if (trace[i] !== 1'b1) begin
        if (run == 0) starts.push_back(i);
        run++;
      end else if (run != 0) begin
        lens.push_back(run);
        run = 0;
      end
    end
    if (run != 0) lens.push_back(run);
    if (starts.size() >= 2)
      gap_min = starts[1] - (starts[0] + lens[0]);
    chk("pulse_cnt", starts.size(), 2);
    for (int k = 0; k < 2; k++) begin
      chk("pulse_start", k < starts.size() ? starts[k] : -1,
          exp_q.pop_front());
      chk("pulse_len", k < lens.size() ? lens[k] : -1,
          exp_q.pop_front());
    end
    chk("pulse_gap", 32'(gap_min >= G), 1);

    // CONTROL write mid-pulse aborts the pulse.
    wr(2'd0, 32'hFF);
    event_in = 8'h01;
    tick();
    event_in = '0;
    tick();
    tick();
    tick();
    chk("ctl_mid", nint, 0);
    wr(2'd2, 32'h01);
    chk("ctl_abort", nint, 1);
    count_low(30, lows);
    chk("ctl_noresid", lows, 0);

    // Reset mid-pulse.
    wr(2'd0, 32'h01);
    event_in = 8'h01;
    tick();
    event_in = '0;
    tick();
    tick();
    tick();
    chk("rst_mid", nint, 0);
    reset = 1'b1;
    tick();
    chk("rst_abort", nint, 1);
    chk("rst_rd0", bus.readdata, 0);
    reset = 1'b0;
    count_low(30, lows);
    chk("rst_noresid", lows, 0);
    rd(2'd2, 0, "rst_ctrl");
    rd(2'd1, 0, "rst_en");
    rd(2'd0, 0, "rst_stat");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
